// File: rtl/pll_lock_reset_seq.sv
// Purpose: qualifies up to NUM_LOCKS PLL lock inputs (synchronise, filter, hold-off) and then releases the fabric reset.
// Latency: release at E(SYNC_STAGES+LOCK_FILTER+RST_HOLD) after locks go high; the reset asserts at F(SYNC_STAGES) after any lock drops.
// Backpressure: none; this is a free-running monitor. Status flags are sticky until CLR_STATUS.
//
// Ports:
//   CLK            fabric clock, rising edge only
//   RESETN         synchronous active-low reset
//   PLL_LOCK       asynchronous lock indications, one per PLL
//   CLR_STATUS     single-cycle pulse that clears LOCK_LOST and LOSS_COUNT
//   FABRIC_RESET_N active-low fabric reset; high only in RUN
//   ALL_LOCKED     AND of the synchronised lock bits
//   LOCK_LOST      sticky per-channel loss-of-lock flags (set on RUN exit)
//   LOSS_COUNT     saturating count of RUN-state loss events
//   SEQ_STATE      0 WAIT_LOCK, 1 FILTER, 2 HOLD, 3 RUN
module pll_lock_reset_seq #(
  parameter int NUM_LOCKS   = 1,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 16,
  parameter int RST_HOLD    = 64,
  parameter int CNT_W       = 8
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  input  logic [NUM_LOCKS-1:0] PLL_LOCK,
  input  logic                 CLR_STATUS,
  output logic                 FABRIC_RESET_N,
  output logic                 ALL_LOCKED,
  output logic [NUM_LOCKS-1:0] LOCK_LOST,
  output logic [CNT_W-1:0]     LOSS_COUNT,
  output logic [1:0]           SEQ_STATE
);

  // FILTER and HOLD share a single phase counter sized for the longer of the two.
  localparam int MAX_PH = (LOCK_FILTER > RST_HOLD) ? LOCK_FILTER : RST_HOLD;
  localparam int PH_W   = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;
  localparam logic [PH_W-1:0]  FILT_LAST = PH_W'(LOCK_FILTER - 1);
  localparam logic [PH_W-1:0]  HOLD_LAST = PH_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_FILTER = 2'd1,
    ST_HOLD   = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  logic [NUM_LOCKS-1:0][SYNC_STAGES-1:0] sync_q;
  logic [NUM_LOCKS-1:0]                  lk_s;
  logic                                  all_s;
  state_t                                state;
  logic [PH_W-1:0]                       ph_cnt;

  // Per-channel synchroniser chains; bit 0 is the first (metastable) stage.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      sync_q <= '0;
    end else begin
      for (int i = 0; i < NUM_LOCKS; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], PLL_LOCK[i]};
      end
    end
  end

  always_comb begin
    lk_s = '0;
    for (int i = 0; i < NUM_LOCKS; i++) begin
      lk_s[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  assign all_s      = &lk_s;
  assign ALL_LOCKED = all_s;
  assign SEQ_STATE  = state;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state          <= ST_WAIT;
      ph_cnt         <= '0;
      FABRIC_RESET_N <= 1'b0;
      LOCK_LOST      <= '0;
      LOSS_COUNT     <= '0;
    end else begin
      // A clear is applied first; a loss event on the same edge overrides it below.
      if (CLR_STATUS) begin
        LOCK_LOST  <= '0;
        LOSS_COUNT <= '0;
      end

      case (state)
        ST_WAIT: begin
          if (all_s) begin
            state  <= ST_FILTER;
            ph_cnt <= '0;
          end
        end

        // Drops during qualification just restart the sequence; they are not losses.
        ST_FILTER: begin
          if (!all_s) begin
            state <= ST_WAIT;
          end else if (ph_cnt == FILT_LAST) begin
            state  <= ST_HOLD;
            ph_cnt <= '0;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end

        ST_HOLD: begin
          if (!all_s) begin
            state <= ST_WAIT;
          end else if (ph_cnt == HOLD_LAST) begin
            state          <= ST_RUN;
            FABRIC_RESET_N <= 1'b1;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end

        ST_RUN: begin
          if (!all_s) begin
            state          <= ST_WAIT;
            FABRIC_RESET_N <= 1'b0;
            LOCK_LOST      <= (CLR_STATUS ? '0 : LOCK_LOST) | ~lk_s;
            if (CLR_STATUS) begin
              LOSS_COUNT <= CNT_W'(1);
            end else if (LOSS_COUNT != CNT_MAX) begin
              LOSS_COUNT <= LOSS_COUNT + 1'b1;
            end
          end
        end

        default: state <= ST_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
module tb_pll_lock_reset_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Instance A: two locks, 2-bit loss counter, default timing (release at E82).
  logic       resetn_a, clr_a;
  logic [1:0] lock_a;
  logic       frn_a, all_a;
  logic [1:0] lost_a, cnt_a, st_a;

  // Instance B: timing corner, one lock, SYNC_STAGES=3, LOCK_FILTER=RST_HOLD=1.
  logic       resetn_b, clr_b;
  logic [0:0] lock_b;
  logic       frn_b, all_b;
  logic [0:0] lost_b;
  logic [7:0] cnt_b;
  logic [1:0] st_b;

  pll_lock_reset_seq #(
    .NUM_LOCKS(2), .SYNC_STAGES(2), .LOCK_FILTER(16), .RST_HOLD(64), .CNT_W(2)
  ) dut_a (
    .CLK(clk), .RESETN(resetn_a), .PLL_LOCK(lock_a), .CLR_STATUS(clr_a),
    .FABRIC_RESET_N(frn_a), .ALL_LOCKED(all_a), .LOCK_LOST(lost_a),
    .LOSS_COUNT(cnt_a), .SEQ_STATE(st_a)
  );

  pll_lock_reset_seq #(
    .NUM_LOCKS(1), .SYNC_STAGES(3), .LOCK_FILTER(1), .RST_HOLD(1), .CNT_W(8)
  ) dut_b (
    .CLK(clk), .RESETN(resetn_b), .PLL_LOCK(lock_b), .CLR_STATUS(clr_b),
    .FABRIC_RESET_N(frn_b), .ALL_LOCKED(all_b), .LOCK_LOST(lost_b),
    .LOSS_COUNT(cnt_b), .SEQ_STATE(st_b)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Inputs for E0 are already applied at the current falling edge.
  task automatic test_release_a(input string tag);
    logic [1:0] exp_st;
    for (int e = 0; e <= 82; e++) begin
      tick(1);
      exp_st = (e < 2) ? 2'd0 : (e < 18) ? 2'd1 : (e < 82) ? 2'd2 : 2'd3;
      checks++;
      if (st_a !== exp_st) begin
        fails++;
        $display("FAIL %s_state E%0d: got %0d want %0d", tag, e, st_a, exp_st);
      end
      checks++;
      if (frn_a !== (e >= 82)) begin
        fails++;
        $display("FAIL %s_frn E%0d: got %b want %b", tag, e, frn_a, (e >= 82));
      end
      checks++;
      if (all_a !== (e >= 1)) begin
        fails++;
        $display("FAIL %s_all E%0d: got %b want %b", tag, e, all_a, (e >= 1));
      end
    end
  endtask

  task automatic check_reset_a(input string tag);
    checks++;
    if ({frn_a, all_a, lost_a, cnt_a, st_a} !== 8'h00) begin
      fails++;
      $display("FAIL %s: frn=%b all=%b lost=%b cnt=%0d st=%0d want all zero",
               tag, frn_a, all_a, lost_a, cnt_a, st_a);
    end
  endtask

  task automatic test_reset;
    resetn_a = 1'b0; resetn_b = 1'b0;
    lock_a = 2'b00; lock_b = 1'b0;
    clr_a = 1'b0; clr_b = 1'b0;
    tick(2);
    check_reset_a("reset_a");
    checks++;
    if ({frn_b, all_b, lost_b, cnt_b, st_b} !== 13'h0) begin
      fails++;
      $display("FAIL reset_b: frn=%b all=%b lost=%b cnt=%0d st=%0d want all zero",
               frn_b, all_b, lost_b, cnt_b, st_b);
    end
    resetn_a = 1'b1; resetn_b = 1'b1;
  endtask

  task automatic test_release;
    lock_a = 2'b11;
    test_release_a("release");
  endtask

  task automatic test_run_loss;
    lock_a = 2'b10;
    tick(1);
    checks++;
    if (frn_a !== 1'b1) begin fails++; $display("FAIL runloss_F0_frn: got %b want 1", frn_a); end
    tick(1);
    checks++;
    if (frn_a !== 1'b1 || all_a !== 1'b0) begin
      fails++;
      $display("FAIL runloss_F1: frn=%b all=%b want frn=1 all=0", frn_a, all_a);
    end
    tick(1);
    checks++;
    if (frn_a !== 1'b0 || st_a !== 2'd0 || lost_a !== 2'b01 || cnt_a !== 2'd1) begin
      fails++;
      $display("FAIL runloss_F2: frn=%b st=%0d lost=%b cnt=%0d want 0 0 01 1",
               frn_a, st_a, lost_a, cnt_a);
    end
    lock_a = 2'b11;
    test_release_a("relock");
    checks++;
    if (lost_a !== 2'b01 || cnt_a !== 2'd1) begin
      fails++;
      $display("FAIL relock_status: lost=%b cnt=%0d want 01 1", lost_a, cnt_a);
    end
  endtask

  // Drop the masked locks from RUN, check the loss edge, then re-lock into RUN.
  task automatic loss_a(input logic [1:0] drop, input logic [1:0] exp_lost,
                        input logic [1:0] exp_cnt, input string tag);
    lock_a = 2'b11 & ~drop;
    tick(3);
    checks++;
    if (frn_a !== 1'b0 || st_a !== 2'd0 || lost_a !== exp_lost || cnt_a !== exp_cnt) begin
      fails++;
      $display("FAIL %s: frn=%b st=%0d lost=%b cnt=%0d want 0 0 %b %0d",
               tag, frn_a, st_a, lost_a, cnt_a, exp_lost, exp_cnt);
    end
    lock_a = 2'b11;
    tick(83);
    checks++;
    if (st_a !== 2'd3 || frn_a !== 1'b1) begin
      fails++;
      $display("FAIL %s_rerun: st=%0d frn=%b want 3 1", tag, st_a, frn_a);
    end
  endtask

  task automatic test_saturation_clear;
    loss_a(2'b10, 2'b11, 2'd2, "loss2");
    loss_a(2'b01, 2'b11, 2'd3, "loss3");
    loss_a(2'b01, 2'b11, 2'd3, "loss4_sat");
    loss_a(2'b10, 2'b11, 2'd3, "loss5_sat");
    clr_a = 1'b1;
    tick(1);
    clr_a = 1'b0;
    checks++;
    if (cnt_a !== 2'd0 || lost_a !== 2'b00 || st_a !== 2'd3 || frn_a !== 1'b1) begin
      fails++;
      $display("FAIL clear: cnt=%0d lost=%b st=%0d frn=%b want 0 00 3 1",
               cnt_a, lost_a, st_a, frn_a);
    end
    loss_a(2'b01, 2'b01, 2'd1, "loss_after_clear");
    // Clear pulse lands exactly on the loss edge (F2): the new loss must win.
    lock_a = 2'b01;
    tick(2);
    checks++;
    if (frn_a !== 1'b1) begin fails++; $display("FAIL coincide_F1_frn: got %b want 1", frn_a); end
    clr_a = 1'b1;
    tick(1);
    clr_a = 1'b0;
    checks++;
    if (lost_a !== 2'b10 || cnt_a !== 2'd1 || frn_a !== 1'b0 || st_a !== 2'd0) begin
      fails++;
      $display("FAIL coincide: lost=%b cnt=%0d frn=%b st=%0d want 10 1 0 0",
               lost_a, cnt_a, frn_a, st_a);
    end
  endtask

  task automatic test_reset_mid;
    lock_a = 2'b11;
    tick(21);
    checks++;
    if (st_a !== 2'd2) begin fails++; $display("FAIL pre_hold_state: got %0d want 2", st_a); end
    resetn_a = 1'b0;
    tick(1);
    check_reset_a("reset_in_hold");
    resetn_a = 1'b1;
    test_release_a("after_hold_reset");
    resetn_a = 1'b0;
    tick(1);
    check_reset_a("reset_in_run");
    resetn_a = 1'b1;
    test_release_a("after_run_reset");
  endtask

  task automatic test_filter_abort;
    resetn_a = 1'b0;
    lock_a   = 2'b00;
    tick(1);
    resetn_a = 1'b1;
    lock_a   = 2'b11;
    tick(13);
    checks++;
    if (st_a !== 2'd1) begin fails++; $display("FAIL abort_pre_state: got %0d want 1", st_a); end
    lock_a = 2'b01;
    tick(3);
    checks++;
    if (st_a !== 2'd0 || frn_a !== 1'b0) begin
      fails++;
      $display("FAIL abort_state: st=%0d frn=%b want 0 0", st_a, frn_a);
    end
    tick(2);
    checks++;
    if (lost_a !== 2'b00 || cnt_a !== 2'd0) begin
      fails++;
      $display("FAIL abort_status: lost=%b cnt=%0d want 00 0", lost_a, cnt_a);
    end
    lock_a = 2'b11;
    test_release_a("abort_restart");
  endtask

  task automatic test_corner;
    logic [1:0] exp_st;
    lock_b = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      tick(1);
      exp_st = (e < 3) ? 2'd0 : 2'(e - 2);
      checks++;
      if (st_b !== exp_st || frn_b !== (e >= 5) || all_b !== (e >= 2)) begin
        fails++;
        $display("FAIL corner E%0d: st=%0d frn=%b all=%b want %0d %b %b",
                 e, st_b, frn_b, all_b, exp_st, (e >= 5), (e >= 2));
      end
    end
    lock_b = 1'b0;
    tick(3);
    checks++;
    if (frn_b !== 1'b1) begin fails++; $display("FAIL corner_loss_F2_frn: got %b want 1", frn_b); end
    tick(1);
    checks++;
    if (frn_b !== 1'b0 || lost_b !== 1'b1 || cnt_b !== 8'd1) begin
      fails++;
      $display("FAIL corner_loss_F3: frn=%b lost=%b cnt=%0d want 0 1 1", frn_b, lost_b, cnt_b);
    end
  endtask

  initial begin
    resetn_a = 1'b0; resetn_b = 1'b0;
    lock_a = 2'b00; lock_b = 1'b0;
    clr_a = 1'b0; clr_b = 1'b0;
    test_reset();
    test_release();
    test_run_loss();
    test_saturation_clear();
    test_reset_mid();
    test_filter_abort();
    test_corner();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
